// File: rtl/fp_div_pkg.sv
// Shared constants and pipeline payload types for the FP divide normalise/round stage.
package fp_div_pkg;

    localparam int unsigned Q_W      = 48;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned IN_EXP_W = 10;
    // Internal exponent width: wide enough that exp + offset + carry never wraps.
    localparam int unsigned IE_W     = 12;
    localparam int unsigned LZ_W     = 6;

    localparam int          BIAS     = 127;
    localparam int          EXP_MAX  = 255;
    localparam int          LEAD_POS = 46;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    // S1 -> S2 payload: raw quotient plus its leading-zero count.
    typedef struct packed {
        logic                valid;
        logic [Q_W-1:0]      quot;
        logic [LZ_W-1:0]     lz;
        logic [IN_EXP_W-1:0] exp;
        logic                sign;
        logic                nan;
        logic                inf;
        logic                zero;
        logic                zero_q;
    } s1_t;

    // S2 -> S3 payload: normalised fraction with round bits and adjusted exponent.
    typedef struct packed {
        logic             valid;
        logic [MAN_W-1:0] frac;
        logic             guard;
        logic             rnd;
        logic             sticky;
        logic [IE_W-1:0]  exp_n;
        logic             sign;
        logic             nan;
        logic             inf;
        logic             zero;
    } s2_t;

endpackage

// File: rtl/lzc48.sv
// Combinational 48-bit leading-zero counter.
module lzc48
    import fp_div_pkg::*;
(
    input  logic [Q_W-1:0]  i_q,
    output logic [LZ_W-1:0] o_cnt,
    output logic            o_all_zero
);

    // Highest set bit wins because it is visited last.
    always_comb begin
        o_cnt = LZ_W'(Q_W);
        for (int i = 0; i < int'(Q_W); i++) begin
            if (i_q[i]) begin
                o_cnt = LZ_W'(int'(Q_W) - 1 - i);
            end
        end
    end

    assign o_all_zero = ~|i_q;

endmodule

// File: rtl/fp_div_norm_round.sv
// Normalise, round-to-nearest-even and pack the mantissa-divider quotient into binary32.
module fp_div_norm_round
    import fp_div_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [Q_W-1:0]      in_quot,
    input  logic [IN_EXP_W-1:0] in_exp,
    input  logic                in_sign,
    input  logic                in_nan,
    input  logic                in_inf,
    input  logic                in_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_result,
    output logic                out_ovf,
    output logic                out_unf,
    output logic                out_inx
);

    localparam int unsigned G_BIT = Q_W - 2 - MAN_W;

    logic                   w_advance;
    logic [LZ_W-1:0]        w_lz;
    logic                   w_all_zero;
    logic [Q_W-2:0]         w_norm;
    logic [LZ_W-1:0]        w_p;
    logic signed [IE_W-1:0] w_exp_n;
    logic                   w_inc;
    logic [MAN_W:0]         w_sum;
    logic signed [IE_W-1:0] w_exp_r;
    logic [31:0]            w_result;
    logic                   w_ovf;
    logic                   w_unf;
    logic                   w_inx;

    s1_t r_s1;
    s2_t r_s2;

    assign w_advance = !out_valid | out_ready;
    assign in_ready  = w_advance;

    lzc48 u_lzc (
        .i_q       (in_quot),
        .o_cnt     (w_lz),
        .o_all_zero(w_all_zero)
    );

    // S1: capture the beat with its leading-zero count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= '0;
        end else if (w_advance) begin
            r_s1.valid  <= in_valid;
            r_s1.quot   <= in_quot;
            r_s1.lz     <= w_lz;
            r_s1.exp    <= in_exp;
            r_s1.sign   <= in_sign;
            r_s1.nan    <= in_nan;
            r_s1.inf    <= in_inf;
            r_s1.zero   <= in_zero;
            r_s1.zero_q <= w_all_zero;
        end
    end

    // S2 comb: shift leading one to bit 47 (dropped) and offset exponent by p - 46.
    always_comb begin
        w_norm  = (Q_W-1)'(r_s1.quot << r_s1.lz);
        w_p     = LZ_W'(Q_W - 1) - r_s1.lz;
        w_exp_n = $signed({{(IE_W-IN_EXP_W){r_s1.exp[IN_EXP_W-1]}}, r_s1.exp})
                + ($signed({{(IE_W-LZ_W){1'b0}}, w_p}) - $signed(IE_W'(LEAD_POS)));
    end

    // S2: register fraction, guard/round/sticky and adjusted exponent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2 <= '0;
        end else if (w_advance) begin
            r_s2.valid  <= r_s1.valid;
            r_s2.frac   <= w_norm[Q_W-2 -: MAN_W];
            r_s2.guard  <= w_norm[G_BIT];
            r_s2.rnd    <= w_norm[G_BIT-1];
            r_s2.sticky <= |w_norm[G_BIT-2:0];
            r_s2.exp_n  <= w_exp_n;
            r_s2.sign   <= r_s1.sign;
            r_s2.nan    <= r_s1.nan;
            r_s2.inf    <= r_s1.inf;
            r_s2.zero   <= r_s1.zero | r_s1.zero_q;
        end
    end

    // S3 comb: RNE increment, range check, then special-case override.
    always_comb begin
        w_inc    = r_s2.guard & (r_s2.rnd | r_s2.sticky | r_s2.frac[0]);
        w_sum    = {1'b0, r_s2.frac} + (MAN_W+1)'(w_inc);
        w_exp_r  = $signed(r_s2.exp_n) + $signed({{(IE_W-1){1'b0}}, w_sum[MAN_W]});
        w_inx    = r_s2.guard | r_s2.rnd | r_s2.sticky;
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        w_result = {r_s2.sign, w_exp_r[EXP_W-1:0], w_sum[MAN_W-1:0]};
        if (w_exp_r >= $signed(IE_W'(EXP_MAX))) begin
            w_result = {r_s2.sign, 8'hFF, 23'd0};
            w_ovf    = 1'b1;
            w_inx    = 1'b1;
        end else if (w_exp_r <= $signed(IE_W'(0))) begin
            w_result = {r_s2.sign, 31'd0};
            w_unf    = 1'b1;
            w_inx    = 1'b1;
        end
        if (r_s2.nan) begin
            w_result = QNAN;
            w_ovf    = 1'b0;
            w_unf    = 1'b0;
            w_inx    = 1'b0;
        end else if (r_s2.inf) begin
            w_result = {r_s2.sign, 8'hFF, 23'd0};
            w_ovf    = 1'b0;
            w_unf    = 1'b0;
            w_inx    = 1'b0;
        end else if (r_s2.zero) begin
            w_result = {r_s2.sign, 31'd0};
            w_ovf    = 1'b0;
            w_unf    = 1'b0;
            w_inx    = 1'b0;
        end
    end

    // S3: output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            out_inx    <= 1'b0;
        end else if (w_advance) begin
            out_valid <= r_s2.valid;
            if (r_s2.valid) begin
                out_result <= w_result;
                out_ovf    <= w_ovf;
                out_unf    <= w_unf;
                out_inx    <= w_inx;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_norm_round.sv
// Randomised and directed bench for fp_div_norm_round with a behavioural reference model.
module tb_fp_div_norm_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_quot;
    logic [9:0]  in_exp;
    logic        in_sign, in_nan, in_inf, in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf, out_unf, out_inx;

    always #5 clk = ~clk;

    fp_div_norm_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_quot   (in_quot),
        .in_exp    (in_exp),
        .in_sign   (in_sign),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_inx   (out_inx)
    );

    typedef struct {
        logic [47:0] q;
        logic [9:0]  e;
        logic        s;
        logic        nan;
        logic        inf;
        logic        zero;
    } beat_t;

    typedef struct {
        logic [34:0] exp_v;
        logic [34:0] lit;
        bit          has_lit;
        int          acc;
    } sb_t;

    sb_t         sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          step_idx = 0;
    int          rdy_low  = 0;
    bit          chk_lat  = 1'b0;
    bit          hold_v   = 1'b0;
    logic [34:0] held;
    beat_t       idle;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: exact value scaling with integer mantissa and remainder-based RNE.
    function automatic logic [34:0] ref_model(input beat_t b);
        int          p;
        int          e;
        logic [47:0] n;
        longint      mant;
        longint      rem;
        logic        inx;
        logic [22:0] f;
        if (b.nan) return {32'h7FC0_0000, 3'b000};
        if (b.inf) return {b.s, 8'hFF, 23'd0, 3'b000};
        if (b.zero || b.q == 48'd0) return {b.s, 31'd0, 3'b000};
        p = 0;
        for (int i = 0; i < 48; i++) if (b.q[i]) p = i;
        n    = b.q << (47 - p);
        mant = longint'(n[47:24]);
        rem  = longint'(n[23:0]);
        e    = int'($signed(b.e)) + p - 46;
        inx  = (rem != 0);
        if (rem > (64'd1 << 23) || (rem == (64'd1 << 23) && mant[0])) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) return {b.s, 8'hFF, 23'd0, 3'b101};
        if (e <= 0)   return {b.s, 31'd0, 3'b011};
        f = mant[22:0];
        return {b.s, 8'(e), f, 2'b00, inx};
    endfunction

    function automatic beat_t rand_beat();
        beat_t       b;
        logic [63:0] t;
        int          r;
        t = {$urandom(), $urandom()};
        r = int'($urandom_range(0, 7));
        if (r < 4)       b.q = {2'b01, t[45:0]};
        else if (r < 6)  b.q = {3'b001, t[44:0]};
        else if (r == 6) b.q = t[47:0] >> $urandom_range(0, 47);
        else             b.q = ($urandom_range(0, 3) == 0) ? 48'd0 : t[47:0];
        if ($urandom_range(0, 7) == 0) b.e = 10'($urandom());
        else                           b.e = 10'(int'($urandom_range(0, 290)) - 15);
        b.s    = 1'($urandom());
        r      = int'($urandom_range(0, 15));
        b.nan  = (r == 0);
        b.inf  = (r == 1);
        b.zero = (r == 2);
        return b;
    endfunction

    // One clock: drive at negedge, then score the handshakes the next posedge will take.
    task automatic step(input logic rst, input logic v, input beat_t b, input logic ordy,
                        input logic [34:0] lit, input bit has_lit, output logic acc);
        sb_t         ent;
        logic [34:0] obs;
        @(negedge clk);
        rst_n     = rst;
        in_valid  = v;
        in_quot   = b.q;
        in_exp    = b.e;
        in_sign   = b.s;
        in_nan    = b.nan;
        in_inf    = b.inf;
        in_zero   = b.zero;
        out_ready = ordy;
        #1;
        obs = {out_result, out_ovf, out_unf, out_inx};
        acc = 1'b0;
        if (hold_v) begin
            check_eq("stall_hold", {out_valid, obs}, {1'b1, held});
            hold_v = 1'b0;
        end
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (!in_ready) rdy_low++;
            if (out_valid && !out_ready) begin
                hold_v = 1'b1;
                held   = obs;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", out_valid, 0);
                end else begin
                    ent = sb.pop_front();
                    check_eq("result_model", obs, ent.exp_v);
                    if (ent.has_lit) check_eq("result_literal", obs, ent.lit);
                    if (chk_lat) check_eq("latency", step_idx - ent.acc, 3);
                end
            end
            acc = in_valid & in_ready;
            if (acc) sb.push_back('{ref_model(b), lit, has_lit, step_idx});
        end
        step_idx++;
    endtask

    task automatic drain(input string tag);
        logic a;
        for (int i = 0; i < 30 && sb.size() != 0; i++) step(1'b1, 1'b0, idle, 1'b1, '0, 1'b0, a);
        check_eq(tag, sb.size(), 0);
    endtask

    initial begin
        beat_t       dv[13];
        logic [34:0] de[13];
        beat_t       b;
        logic        a;
        int          sent;
        int          cyc;
        int          low0;

        idle      = '{q: 48'd0, e: 10'd0, s: 1'b0, nan: 1'b0, inf: 1'b0, zero: 1'b0};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_quot   = '0;
        in_exp    = '0;
        in_sign   = 1'b0;
        in_nan    = 1'b0;
        in_inf    = 1'b0;
        in_zero   = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        repeat (2) step(1'b0, 1'b0, idle, 1'b1, '0, 1'b0, a);
        step(1'b1, 1'b0, idle, 1'b1, '0, 1'b0, a);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_result", out_result, 0);
        check_eq("rst_flags", {out_ovf, out_unf, out_inx}, 0);
        check_eq("rst_ready", in_ready, 1);

        // Directed vectors with literal expectations.
        dv[0]  = '{48'h6000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0}; de[0]  = {32'h3FC0_0000, 3'b000};
        dv[1]  = '{48'h3000_0000_0000, 10'd128, 1'b0, 1'b0, 1'b0, 1'b0}; de[1]  = {32'h3FC0_0000, 3'b000};
        dv[2]  = '{48'h4000_0040_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0}; de[2]  = {32'h3F80_0000, 3'b001};
        dv[3]  = '{48'h4000_00C0_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0}; de[3]  = {32'h3F80_0002, 3'b001};
        dv[4]  = '{48'h7FFF_FFFF_FFFF, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0}; de[4]  = {32'h4000_0000, 3'b001};
        dv[5]  = '{48'h4000_0000_0000, 10'd255, 1'b1, 1'b0, 1'b0, 1'b0}; de[5]  = {32'hFF80_0000, 3'b101};
        dv[6]  = '{48'h4000_0000_0000, 10'd0,   1'b0, 1'b0, 1'b0, 1'b0}; de[6]  = {32'h0000_0000, 3'b011};
        dv[7]  = '{48'h4000_0000_0000, 10'd127, 1'b1, 1'b1, 1'b0, 1'b0}; de[7]  = {32'h7FC0_0000, 3'b000};
        dv[8]  = '{48'h4000_0000_0000, 10'd127, 1'b1, 1'b0, 1'b1, 1'b0}; de[8]  = {32'hFF80_0000, 3'b000};
        dv[9]  = '{48'h4000_0000_0000, 10'd127, 1'b1, 1'b0, 1'b0, 1'b1}; de[9]  = {32'h8000_0000, 3'b000};
        dv[10] = '{48'h0000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0}; de[10] = {32'h0000_0000, 3'b000};
        dv[11] = '{48'h4000_0000_0000, 10'd1,   1'b0, 1'b0, 1'b0, 1'b0}; de[11] = {32'h0080_0000, 3'b000};
        dv[12] = '{48'h7FFF_FFFF_FFFF, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0}; de[12] = {32'h7F80_0000, 3'b101};
        chk_lat = 1'b1;
        sent    = 0;
        for (int i = 0; i < 40 && sent < 13; i++) begin
            step(1'b1, 1'b1, dv[sent], 1'b1, de[sent], 1'b1, a);
            if (a) sent++;
        end
        check_eq("directed_sent", sent, 13);
        drain("directed_drain");
        chk_lat = 1'b0;

        // Backpressure: five back-to-back beats, consumer stalls four cycles mid-stream.
        low0 = rdy_low;
        sent = 0;
        cyc  = 0;
        b    = rand_beat();
        b.nan = 1'b0; b.inf = 1'b0; b.zero = 1'b0;
        while (sent < 5 && cyc < 40) begin
            step(1'b1, 1'b1, b, !(cyc >= 3 && cyc < 7), '0, 1'b0, a);
            if (a) begin
                sent++;
                b = rand_beat();
                b.nan = 1'b0; b.inf = 1'b0; b.zero = 1'b0;
            end
            cyc++;
        end
        check_eq("bp_sent", sent, 5);
        check_eq("bp_ready_drop", rdy_low > low0, 1);
        drain("bp_drain");

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            b = rand_beat();
            step(1'b1, 1'b1, b, 1'b1, '0, 1'b0, a);
        end
        step(1'b0, 1'b0, idle, 1'b0, '0, 1'b0, a);
        step(1'b1, 1'b0, idle, 1'b1, '0, 1'b0, a);
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_ready", in_ready, 1);
        repeat (8) step(1'b1, 1'b0, idle, 1'b1, '0, 1'b0, a);
        check_eq("midrst_quiet", sb.size(), 0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            b = rand_beat();
            step(1'b1, ($urandom_range(0, 3) != 0), b, ($urandom_range(0, 3) != 0), '0, 1'b0, a);
        end
        drain("random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
